// File: rtl/calc_op_sequencer_pkg.sv
// Shared constants, key indices, opcode/state encodings and small helpers
// for the keypad calculator sequencer.
package calc_pkg;

  localparam int KEY_W     = 9;
  localparam int RES_W     = 14;
  localparam int CONV_ITER = 14;
  localparam int OPND_W    = 7;

  localparam int KEY_MODE = 0;
  localparam int KEY_DIV  = 1;
  localparam int KEY_MUL  = 2;
  localparam int KEY_SUB  = 3;
  localparam int KEY_ADD  = 4;
  localparam int KEY_INC1 = 5;
  localparam int KEY_INC2 = 6;
  localparam int KEY_INC3 = 7;
  localparam int KEY_INC4 = 8;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_EXEC, ST_CONV, ST_DONE} state_e;

  function automatic logic is_onehot(input logic [KEY_W-1:0] k);
    return (k != '0) && ((k & (k - KEY_W'(1))) == '0);
  endfunction

  // tens*10 + ones as tens*8 + tens*2 + ones, keeping a multiplier out of the path
  function automatic logic [OPND_W-1:0] bcd2_to_bin(input logic [3:0] tens,
                                                     input logic [3:0] ones);
    return {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};
  endfunction

  function automatic logic [3:0] inc_digit(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic op_e key_to_op(input logic [KEY_W-1:0] k);
    if (k[KEY_SUB])      return OP_SUB;
    else if (k[KEY_MUL]) return OP_MUL;
    else if (k[KEY_DIV]) return OP_DIV;
    else                 return OP_ADD;
  endfunction

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Keypad-to-sequencer and sequencer-to-display signal bundle.
interface calc_op_sequencer_if;
  import calc_pkg::*;

  logic [KEY_W-1:0] key;
  logic [3:0]       num1, num2, num3, num4;
  logic [3:0]       res3, res2, res1, res0;
  logic             neg;
  logic             err;
  logic             mode;
  logic             busy;
  logic             res_valid;

  modport master (
    output key,
    input  num1, num2, num3, num4, res3, res2, res1, res0,
    input  neg, err, mode, busy, res_valid
  );

  modport slave (
    input  key,
    output num1, num2, num3, num4, res3, res2, res1, res0,
    output neg, err, mode, busy, res_valid
  );
endinterface

// File: rtl/calc_op_sequencer_bin_to_bcd_seq.sv
// Iterative double-dabble converter: start performs the first shift on bin,
// done pulses once all CONV_ITER shifts have been applied.
module bin_to_bcd_seq
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RES_W-1:0] bin,
  output logic             done,
  output logic [3:0]       bcd3,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0
);

  logic [15:0]      bcd_q, bcd_src, bcd_adj;
  logic [RES_W-1:0] sh_q, sh_src;
  logic [3:0]       cnt_q;

  always_comb begin
    bcd_src = start ? '0 : bcd_q;
    sh_src  = start ? bin : sh_q;
    bcd_adj = bcd_src;
    for (int i = 0; i < 4; i++) begin
      if (bcd_src[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd_src[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
      done  <= 1'b0;
    end else if (start) begin
      bcd_q <= (bcd_adj << 1) | {15'd0, sh_src[RES_W-1]};
      sh_q  <= sh_src << 1;
      cnt_q <= 4'(CONV_ITER - 1);
      done  <= 1'b0;
    end else if (cnt_q != '0) begin
      bcd_q <= (bcd_adj << 1) | {15'd0, sh_src[RES_W-1]};
      sh_q  <= sh_src << 1;
      cnt_q <= cnt_q - 4'd1;
      done  <= (cnt_q == 4'd1);
    end else begin
      done  <= 1'b0;
    end
  end

  assign bcd3 = bcd_q[15:12];
  assign bcd2 = bcd_q[11:8];
  assign bcd1 = bcd_q[7:4];
  assign bcd0 = bcd_q[3:0];

endmodule

// File: rtl/calc_op_sequencer.sv
// Keypad calculator sequencer: operand entry, iterative add/sub/mul/div and
// BCD conversion of the result for the display multiplexer.
//
//   state | meaning
//   IDLE  | accept one-hot keys: digit increment, mode toggle, op start
//   LOAD  | build 7-bit operands from entry digits; divide-by-zero exits here
//   EXEC  | add/sub 1 cycle, mul/div 7 iterations
//   CONV  | double dabble on the result magnitude
//   DONE  | res_valid pulse, result already on the outputs
module calc_op_sequencer
  import calc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  calc_op_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [3:0]        num1_q, num2_q, num3_q, num4_q;
  logic [15:0]       res_q;
  logic              neg_q, err_q, mode_q, neg_pend_q;
  logic [OPND_W-1:0] a_q, b_q, mplier_q, quo_q, rem_q;
  logic [RES_W-1:0]  acc_q, mcand_q;
  logic [2:0]        cnt_q;

  logic              key_ok, op_key, div_zero, exec_last, conv_start, conv_done;
  logic [OPND_W-1:0] a_load, b_load, sub_mag, quo_next, rem_next;
  logic [7:0]        rem_sh, rem_diff;
  logic [RES_W-1:0]  mul_next, exec_res;
  logic [3:0]        cd3, cd2, cd1, cd0;

  always_comb begin
    key_ok   = (state_q == ST_IDLE) && is_onehot(bus.key);
    op_key   = key_ok && (bus.key[KEY_ADD:KEY_DIV] != '0);
    a_load   = bcd2_to_bin(num1_q, num2_q);
    b_load   = bcd2_to_bin(num3_q, num4_q);
    div_zero = (op_q == OP_DIV) && (b_load == '0);

    sub_mag  = (a_q >= b_q) ? a_q - b_q : b_q - a_q;
    mul_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    // partial remainder stays below B, so bit 7 of the difference is the borrow
    rem_sh   = {rem_q, quo_q[OPND_W-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    rem_next = rem_diff[7] ? rem_sh[6:0] : rem_diff[6:0];
    quo_next = {quo_q[5:0], ~rem_diff[7]};

    exec_last = (op_q == OP_ADD) || (op_q == OP_SUB) || (cnt_q == 3'd6);
    exec_res  = '0;
    case (op_q)
      OP_ADD:  exec_res = {7'd0, a_q} + {7'd0, b_q};
      OP_SUB:  exec_res = {7'd0, sub_mag};
      OP_MUL:  exec_res = mul_next;
      OP_DIV:  exec_res = {7'd0, quo_next};
      default: exec_res = '0;
    endcase
    // converter starts on the last EXEC cycle so its final digits land as CONV ends
    conv_start = (state_q == ST_EXEC) && exec_last;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (op_key) state_d = ST_LOAD;
      ST_LOAD: state_d = div_zero ? ST_DONE : ST_EXEC;
      ST_EXEC: if (exec_last) state_d = ST_CONV;
      ST_CONV: if (conv_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_ADD;
      num1_q     <= '0;
      num2_q     <= '0;
      num3_q     <= '0;
      num4_q     <= '0;
      res_q      <= '0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
      mode_q     <= 1'b1;
      neg_pend_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      mplier_q   <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (key_ok) begin
          if (bus.key[KEY_MODE]) mode_q <= ~mode_q;
          if (mode_q) begin
            if (bus.key[KEY_INC1]) num1_q <= inc_digit(num1_q);
            if (bus.key[KEY_INC2]) num2_q <= inc_digit(num2_q);
            if (bus.key[KEY_INC3]) num3_q <= inc_digit(num3_q);
            if (bus.key[KEY_INC4]) num4_q <= inc_digit(num4_q);
          end
          if (op_key) begin
            op_q  <= key_to_op(bus.key);
            neg_q <= 1'b0;
            err_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          a_q        <= a_load;
          b_q        <= b_load;
          mplier_q   <= b_load;
          mcand_q    <= {7'd0, a_load};
          acc_q      <= '0;
          quo_q      <= a_load;
          rem_q      <= '0;
          cnt_q      <= '0;
          neg_pend_q <= 1'b0;
          if (div_zero) begin
            res_q  <= '0;
            err_q  <= 1'b1;
            mode_q <= 1'b0;
          end
        end
        ST_EXEC: begin
          cnt_q      <= cnt_q + 3'd1;
          acc_q      <= mul_next;
          mcand_q    <= mcand_q << 1;
          mplier_q   <= mplier_q >> 1;
          quo_q      <= quo_next;
          rem_q      <= rem_next;
          neg_pend_q <= (op_q == OP_SUB) && (a_q < b_q);
        end
        ST_CONV: if (conv_done) begin
          res_q  <= {cd3, cd2, cd1, cd0};
          neg_q  <= neg_pend_q;
          mode_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  bin_to_bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (exec_res),
    .done  (conv_done),
    .bcd3  (cd3),
    .bcd2  (cd2),
    .bcd1  (cd1),
    .bcd0  (cd0)
  );

  assign bus.num1      = num1_q;
  assign bus.num2      = num2_q;
  assign bus.num3      = num3_q;
  assign bus.num4      = num4_q;
  assign bus.res3      = res_q[15:12];
  assign bus.res2      = res_q[11:8];
  assign bus.res1      = res_q[7:4];
  assign bus.res0      = res_q[3:0];
  assign bus.neg       = neg_q;
  assign bus.err       = err_q;
  assign bus.mode      = mode_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.res_valid = (state_q == ST_DONE);

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Multi-cycle control and datapath sequencer for the 2-digit by 2-digit keypad calculator.
- Input side: one-hot debounced, edge-detected key pulses.
- Owns operand entry digits and the entry/result mode.
- Sequences a shared iterative multiply/divide unit and an iterative binary-to-BCD converter.
- Publishes four result digits with sign and error flags to the display multiplexer.
- Replaces the single-cycle combinational `*`, `/` and `%` result path, so timing closes at the system clock.

Parameters:
KEY_W, 9, width of the one-hot key pulse bus
RES_W, 14, binary result width (99*99 = 9801 fits)
CONV_ITER, 14, double-dabble iterations (equals RES_W)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
key  in  9  one-hot key pulses, one clk wide: [8:5] = increment digits 1..4, [4] = add, [3] = sub, [2] = mul, [1] = div, [0] = mode toggle
num1..num4  out  4 each  entry digits (BCD 0..9); num1,num2 form operand A, num3,num4 form operand B
res3..res0  out  4 each  result digits, thousands..ones
neg  out  1  result negative (subtract with A<B)
err  out  1  divide by zero
mode  out  1  1 = entry display, 0 = result display
busy  out  1  operation in progress
res_valid  out  1  one-cycle pulse when result digits update

Behaviour:
- Reset (sync, active-high): all digits 0, res 0, neg=0, err=0, mode=1, busy=0, res_valid=0, FSM to IDLE. Reset in any state aborts the operation with no partial result update.
- Key acceptance:
  - Keys are sampled only in IDLE.
  - Any key vector that is not exactly one-hot is ignored, including all-zero or two bits set in the same cycle.
  - Keys arriving while busy=1 are dropped, not queued.
- Increment keys act only when mode=1. Digit +1 with 9 wrapping to 0. Single-cycle update, FSM stays in IDLE.
- Mode key toggles mode in IDLE. It does not alter res/neg/err.
- FSM states: IDLE, LOAD, EXEC, CONV, DONE.
- Operation flow:
  - IDLE + op key at cycle t: latch opcode; busy=1 from t+1.
  - LOAD (1 cycle): A = num1*10+num2 and B = num3*10+num4, each 7-bit and built by shift-add (x8 + x2), no multiplier.
    - Divide with B=0: go directly to DONE with err=1.
  - EXEC:
    - add: 1 cycle.
    - sub: 1 cycle; computes |A-B| and sets neg = (A<B).
    - mul: 7 cycles, shift-add over the 7 bits of B.
    - div: 7 cycles, restoring division yielding the quotient; the remainder is discarded.
  - CONV: 14 cycles of double dabble on the 14-bit magnitude.
  - DONE (1 cycle):
    - Write res3..res0, neg and err.
    - err=1 forces res=0 and neg=0.
    - Set mode=0; pulse res_valid; busy=0 next cycle; return to IDLE.
  - Each op clears err and neg on entry to LOAD.
- Latency, from key cycle t to the res_valid cycle:
  - add/sub: t+17
  - mul/div: t+23
  - div-by-zero: t+2
- Result digits hold their value until the next DONE or rst. The entry digits are never modified by an operation.

Decomposition:
- Shared package calc_pkg holds:
  - key bit index constants (KEY_INC1..KEY_INC4, KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_MODE)
  - opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV)
  - FSM state encoding
  - RES_W
- One sub-module, bin_to_bcd_seq: start/done handshake, 14-bit input, four BCD outputs, CONV_ITER cycles. It is shared with any future display path.

Test Plan:
- Enter 1,2,3,4 via the increment keys, pulse add -> busy for cycles t+1..t+17; res_valid at t+17; res=0046, neg=0, mode=0.
- A=23, B=45, sub -> res_valid at t+17; res=0022, neg=1.
- A=99, B=99, mul -> res_valid at t+23; res=9801. Repeat with div -> 0001.
- A=07, B=00, div -> res_valid at t+2; err=1, res=0000. Then mode key -> mode=1, err still 1 until the next op.
- During mul EXEC, pulse add and inc1 -> both ignored; res=9801 and num1 unchanged. Drive key=9'b100000001 in IDLE -> no change.
- Assert rst during CONV -> next cycle busy=0, mode=1, all digits 0, no res_valid pulse. Ten inc1 pulses -> num1 goes 1..9 and then 0.
